infix_to_postfix: RTL
=====================

Name: infix_to_postfix

Overview:
- Sits directly downstream of the ASCII-to-token decoder and consumes its 5-bit token stream.
- Token codes: 0-15 hex digit, 16 '(', 17 ')', 18 '*', 19 '+', 20 '-', 21 '='.
- Accumulates consecutive digit tokens into one operand and reorders infix tokens into a postfix stream using an operator stack (shunting-yard).
- The postfix stream feeds the expression evaluator.

Parameters:
- OPND_W, 16: operand width. Multi-digit accumulation wraps modulo 2^OPND_W.
- STACK_DEPTH, 16: operator stack entries.
- PTR_W, 4: stack pointer width (log2 of STACK_DEPTH).

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tok_valid  in  1  tok_in is valid.
- tok_in  in  5  token code from the decoder.
- tok_ready  out  1  block accepts a token this cycle.
- out_valid  out  1  postfix item valid.
- out_ready  in  1  downstream accepts the item.
- out_is_op  out  1  1 = operator item, 0 = operand item.
- out_data  out  OPND_W  operand value, or operator code zero-extended.
- done  out  1  one-cycle pulse after the last item of an expression.
- err  out  1  sticky syntax or stack error flag.

Behaviour:
- Reset values: out_valid=0, out_is_op=0, out_data=0, done=0, err=0, stack empty, operand accumulator=0, num_pending=0, state=ACCEPT.
- Token transfer: happens on tok_valid && tok_ready.
  - tok_ready = (state==ACCEPT) && !(out_valid && !out_ready).
- Output register: out_valid/out_data/out_is_op are held stable while out_valid && !out_ready. At most one item is emitted per cycle.
- States: ACCEPT, RESOLVE, FLUSH, DONE.
- ACCEPT:
  - Digit token: acc <= {acc[OPND_W-5:0], digit}, num_pending <= 1. No output.
  - Codes 22-31: consumed and ignored.
  - Codes 16-21: latched into cur_tok; go to RESOLVE.
- RESOLVE, one action per cycle when the output slot is free:
  - If num_pending: emit acc as an operand, then clear acc and num_pending. The number is always emitted before any popped operators.
  - Else if cur_tok is '(': push it; go to ACCEPT.
  - Else if cur_tok is ')': if top is an operator, pop and emit it. If top is '(', pop and discard it; go to ACCEPT. If the stack is empty: set err; go to ACCEPT.
  - Else if cur_tok is '*', '+' or '-': while top is an operator with prec(top) >= prec(cur), pop and emit one per cycle. Then push cur_tok; go to ACCEPT. This gives left associativity.
    - prec('*')=2; prec('+')=prec('-')=1; '(' is never popped by precedence.
  - Else if cur_tok is '=': go to FLUSH.
- FLUSH:
  - Pop one entry per cycle and emit operators.
  - A '(' found here is discarded and sets err.
  - When the stack is empty, go to DONE.
- DONE: done=1 for exactly one cycle; then ACCEPT.
  - err holds until the first token accepted after done, where it clears.
- Push when full: the push is dropped and err is set.
- Simultaneous out_ready and a new emit: the register is reloaded in the same cycle, so there is no bubble.
- Reset asserted mid-operation: all state, the stack and the accumulator clear immediately. Any partial expression is discarded with no done pulse.
- Latency: the first item of an operator token appears at most 1 cycle after its acceptance.

Optional Feature:
- Macro: INFIX_TO_POSTFIX_ERR_CHK_EN.
- Defined: err logic as described above.
- Undefined: err is tied to 0.
  - Overflowing pushes are silently dropped.
  - An unmatched ')' is ignored.
  - A stray '(' at '=' is discarded silently.

Decomposition:
- Shared package (also used by the decoder and the evaluator):
  - Token code constants TOK_LPAR=16, TOK_RPAR=17, TOK_MUL=18, TOK_ADD=19, TOK_SUB=20, TOK_EQ=21.
  - Token width constant 5.
  - Precedence function.
  - State enum typedef.
- Sub-module: op_stack.
  - Synchronous LIFO with push, pop, top, empty and full, parameterised by STACK_DEPTH.
  - Top is readable combinationally.

Test Plan:
- Tokens 3,19,4,21 with out_ready=1 -> operand 3, operand 4, op 19, done pulse; err=0.
- Tokens 1,10,18,16,2,19,3,17,21 -> operand 0x1A, operand 2, operand 3, op 19, op 18, done.
- Tokens 8,20,2,20,1,21 -> 8, 2, op 20, 1, op 20 (left associative), done.
- Digits 1,2,3,4,5 then 21, with OPND_W=16 -> single operand 0x2345, done.
- In test 2, hold out_ready=0 for 5 cycles on the first operator -> out_data stays 19 and tok_ready=0 throughout; the stream resumes without loss.
- Tokens 17,21:
  - Macro defined -> err=1, done pulses; err clears on the next accepted token.
  - Macro undefined -> err=0.
- Reset mid-expression after 5,19 -> next tokens 7,21 give operand 7 then done only; stack is empty.

Source files
------------

// File: rtl/infix_to_postfix_pkg.sv
// rtl/infix_to_postfix_pkg.sv - token codes, precedence and state type shared by the token pipeline
package infix_to_postfix_pkg;

    localparam int TOK_W = 5;

    localparam logic [TOK_W-1:0] TOK_LPAR = 5'd16;
    localparam logic [TOK_W-1:0] TOK_RPAR = 5'd17;
    localparam logic [TOK_W-1:0] TOK_MUL  = 5'd18;
    localparam logic [TOK_W-1:0] TOK_ADD  = 5'd19;
    localparam logic [TOK_W-1:0] TOK_SUB  = 5'd20;
    localparam logic [TOK_W-1:0] TOK_EQ   = 5'd21;

    typedef enum logic [1:0] {
        ACCEPT,
        RESOLVE,
        FLUSH,
        DONE
    } state_t;

    // '(' and non-operators get 0 so they are never popped by precedence
    function automatic logic [1:0] prec(input logic [TOK_W-1:0] tok);
        case (tok)
            TOK_MUL:          prec = 2'd2;
            TOK_ADD, TOK_SUB: prec = 2'd1;
            default:          prec = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/infix_to_postfix_if.sv
// rtl/infix_to_postfix_if.sv - token input and postfix output handshake bundle
interface infix_to_postfix_if #(
    parameter int OPND_W = 16
);
    import infix_to_postfix_pkg::*;

    logic              tok_valid;
    logic [TOK_W-1:0]  tok_in;
    logic              tok_ready;
    logic              out_valid;
    logic              out_ready;
    logic              out_is_op;
    logic [OPND_W-1:0] out_data;
    logic              done;
    logic              err;

    modport master (
        output tok_valid, tok_in, out_ready,
        input  tok_ready, out_valid, out_is_op, out_data, done, err
    );

    modport slave (
        input  tok_valid, tok_in, out_ready,
        output tok_ready, out_valid, out_is_op, out_data, done, err
    );

endinterface

// File: rtl/infix_to_postfix_op_stack.sv
// rtl/infix_to_postfix_op_stack.sv - operator LIFO with combinational top-of-stack
module op_stack #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    logic [W-1:0]   mem [DEPTH];
    logic [PTR_W:0] count;
    logic [PTR_W-1:0] top_idx;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign top_idx = PTR_W'(count - 1'b1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // storage needs no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/infix_to_postfix.sv
// rtl/infix_to_postfix.sv - shunting-yard infix to postfix converter; INFIX_TO_POSTFIX_ERR_CHK_EN enables err
module infix_to_postfix
    import infix_to_postfix_pkg::*;
#(
    parameter int OPND_W      = 16,
    parameter int STACK_DEPTH = 16,
    parameter int PTR_W       = 4
) (
    input logic               clk,
    input logic               rst,
    infix_to_postfix_if.slave bus
);

    state_t            state, state_nxt;
    logic [OPND_W-1:0] acc;
    logic              num_pending;
    logic [TOK_W-1:0]  cur_tok;
    logic              out_valid_q, out_is_op_q;
    logic [OPND_W-1:0] out_data_q;

    logic              slot_free, tok_fire, is_digit, is_ctrl;
    logic              push_req, pop, emit, emit_is_op, clr_num;
    logic [OPND_W-1:0] emit_data;
    logic              stk_push, stk_empty, stk_full;
    logic [TOK_W-1:0]  stk_top;
`ifdef INFIX_TO_POSTFIX_ERR_CHK_EN
    logic              err_set, err_q, after_done;
`endif

    assign slot_free     = !out_valid_q || bus.out_ready;
    assign bus.tok_ready = (state == ACCEPT) && slot_free;
    assign tok_fire      = bus.tok_valid && bus.tok_ready;
    assign is_digit      = bus.tok_in < TOK_LPAR;
    assign is_ctrl       = (bus.tok_in >= TOK_LPAR) && (bus.tok_in <= TOK_EQ);
    assign stk_push      = push_req && !stk_full;

    op_stack #(.DEPTH(STACK_DEPTH), .PTR_W(PTR_W), .W(TOK_W)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (pop),
        .din   (cur_tok),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCEPT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        push_req   = 1'b0;
        pop        = 1'b0;
        emit       = 1'b0;
        emit_is_op = 1'b0;
        emit_data  = '0;
        clr_num    = 1'b0;
`ifdef INFIX_TO_POSTFIX_ERR_CHK_EN
        err_set    = 1'b0;
`endif
        case (state)
            ACCEPT: begin
                if (tok_fire && is_ctrl) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                if (!slot_free) begin
                    state_nxt = RESOLVE;
                end else if (num_pending) begin
                    emit      = 1'b1;
                    emit_data = acc;
                    clr_num   = 1'b1;
                end else if (cur_tok == TOK_LPAR) begin
                    push_req  = 1'b1;
                    state_nxt = ACCEPT;
                end else if (cur_tok == TOK_RPAR) begin
                    if (stk_empty) begin
`ifdef INFIX_TO_POSTFIX_ERR_CHK_EN
                        err_set = 1'b1;
`endif
                        state_nxt = ACCEPT;
                    end else if (stk_top == TOK_LPAR) begin
                        pop       = 1'b1;
                        state_nxt = ACCEPT;
                    end else begin
                        pop        = 1'b1;
                        emit       = 1'b1;
                        emit_is_op = 1'b1;
                        emit_data  = OPND_W'(stk_top);
                    end
                end else if (cur_tok == TOK_EQ) begin
                    state_nxt = FLUSH;
                end else if (!stk_empty && stk_top != TOK_LPAR &&
                             prec(stk_top) >= prec(cur_tok)) begin
                    pop        = 1'b1;
                    emit       = 1'b1;
                    emit_is_op = 1'b1;
                    emit_data  = OPND_W'(stk_top);
                end else begin
                    push_req  = 1'b1;
                    state_nxt = ACCEPT;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    if (stk_empty) begin
                        state_nxt = DONE;
                    end else begin
                        pop = 1'b1;
                        if (stk_top == TOK_LPAR) begin
`ifdef INFIX_TO_POSTFIX_ERR_CHK_EN
                            err_set = 1'b1;
`endif
                        end else begin
                            emit       = 1'b1;
                            emit_is_op = 1'b1;
                            emit_data  = OPND_W'(stk_top);
                        end
                    end
                end
            end
            DONE:    state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
`ifdef INFIX_TO_POSTFIX_ERR_CHK_EN
        if (push_req && stk_full) err_set = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            num_pending <= 1'b0;
            cur_tok     <= '0;
            out_valid_q <= 1'b0;
            out_is_op_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (tok_fire && is_digit) begin
                acc         <= {acc[OPND_W-5:0], bus.tok_in[3:0]};
                num_pending <= 1'b1;
            end
            if (tok_fire && is_ctrl) cur_tok <= bus.tok_in;
            if (clr_num) begin
                acc         <= '0;
                num_pending <= 1'b0;
            end
            // reload in the same cycle the old item drains, so no bubble
            if (emit) begin
                out_valid_q <= 1'b1;
                out_is_op_q <= emit_is_op;
                out_data_q  <= emit_data;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef INFIX_TO_POSTFIX_ERR_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            after_done <= 1'b0;
        end else begin
            if (err_set)                      err_q <= 1'b1;
            else if (tok_fire && after_done)  err_q <= 1'b0;
            if (state == DONE)  after_done <= 1'b1;
            else if (tok_fire)  after_done <= 1'b0;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_is_op = out_is_op_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = (state == DONE);

endmodule
